// File: rtl/sweep_check_pkg.sv
// sweep_check_pkg: shared types, widths and the golden gate function for the sweep checker.
package sweep_check_pkg;
   localparam int VEC_W = 3;
   localparam int CNT_W = 4;
   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;
   function automatic logic expected_d(input logic [VEC_W-1:0] v);
      return v[2] & v[1] & ~v[0];
   endfunction
endpackage

// File: rtl/gate_model.sv
// gate_model: golden reference of the gate under test, d = a AND b AND NOT c.
module gate_model
   import sweep_check_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic c,
   output logic d
);
   assign d = expected_d({a, b, c});
endmodule

// File: rtl/sweep_check_ctrl.sv
// sweep_check_ctrl: drives all 8 input vectors into a 3-input gate, settles, samples
// and compares its output against gate_model, reporting mismatch count and first failing vector.
module sweep_check_ctrl
   import sweep_check_pkg::*;
#(
   parameter int SETTLE = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             dut_d,
   output logic             dut_a,
   output logic             dut_b,
   output logic             dut_c,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_count,
   output logic [VEC_W-1:0] first_err_vec
);
   state_t           state_q, state_d;
   logic [VEC_W-1:0] vec_q, vec_d, abc_q, abc_d, first_q, first_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, err_q, err_d;
   logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic             exp_d, mismatch;

   gate_model u_gate (.a(vec_q[2]), .b(vec_q[1]), .c(vec_q[0]), .d(exp_d));

   assign mismatch = dut_d != exp_d;

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      first_d = first_q;
      pass_d  = pass_q;
      case (state_q)
         ST_IDLE: if (start) begin
            state_d = ST_SETTLE;
            vec_d   = '0;
            cnt_d   = '0;
            err_d   = '0;
            first_d = '0;
            pass_d  = 1'b0;
         end
         ST_SETTLE: begin
            state_d = abort ? ST_IDLE : (cnt_q == CNT_W'(SETTLE - 1)) ? ST_SAMPLE : ST_SETTLE;
            cnt_d   = cnt_q + 4'd1;
         end
         ST_SAMPLE: if (abort) state_d = ST_IDLE;
         else begin
            // first_err_vec latches only the earliest failing vector of the sweep
            err_d   = mismatch ? err_q + 4'd1 : err_q;
            first_d = (mismatch && err_q == '0) ? vec_q : first_q;
            cnt_d   = '0;
            if (vec_q == '1) begin
               state_d = ST_DONE;
               pass_d  = err_d == '0;
            end else begin
               state_d = ST_SETTLE;
               vec_d   = vec_q + 3'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = state_d == ST_SETTLE || state_d == ST_SAMPLE;
      done_d = state_d == ST_DONE;
      abc_d  = busy_d ? vec_d : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         vec_q   <= '0;
         cnt_q   <= '0;
         err_q   <= '0;
         first_q <= '0;
         pass_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         abc_q   <= '0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         first_q <= first_d;
         pass_q  <= pass_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         abc_q   <= abc_d;
      end
   end

   assign {dut_a, dut_b, dut_c} = abc_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign pass          = pass_q;
   assign err_count     = err_q;
   assign first_err_vec = first_q;
endmodule

// File: tb/tb_sweep_check_ctrl.sv
// tb_sweep_check_ctrl: directed scenarios plus randomized traffic checked every cycle
// against a sweep-position model of the checker.
module tb_sweep_check_ctrl;
   localparam int S = 2;
   localparam int N = 8 * (S + 1);

   logic       clk = 0, rst_n = 0, start = 0, abort = 0, rnd = 0;
   logic       dut_d, dut_a, dut_b, dut_c, busy, done, pass;
   logic [3:0] err_count;
   logic [2:0] first_err_vec;
   int         mode = 0, checks = 0, errors = 0;
   int         pos = 0, m_err = 0, m_first = 0, m_pass = 0;

   always #5 clk = ~clk;

   sweep_check_ctrl #(.SETTLE(S)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_d(dut_d),
      .dut_a(dut_a), .dut_b(dut_b), .dut_c(dut_c), .busy(busy), .done(done),
      .pass(pass), .err_count(err_count), .first_err_vec(first_err_vec)
   );

   // 0 good gate, 1 stuck-0, 2 stuck-1, 3 random, 4 good except at vector 3
   always_comb begin
      dut_d = dut_a & dut_b & ~dut_c;
      case (mode)
         1: dut_d = 1'b0;
         2: dut_d = 1'b1;
         3: dut_d = rnd;
         4: dut_d = (dut_a & dut_b & ~dut_c) ^ ({dut_a, dut_b, dut_c} == 3'd3);
         default: ;
      endcase
   end

   task automatic chk(input string n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d at %0t", n, act, exp, $time);
      end
   endtask

   // pos: 0 idle, 1..N sweep cycles (each vector S settle cycles then 1 sample), N+1 done
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos = 0; m_err = 0; m_first = 0; m_pass = 0;
      end else if (pos == 0) begin
         if (start) begin pos = 1; m_err = 0; m_first = 0; m_pass = 0; end
      end else if (pos == N + 1) pos = 0;
      else if (abort) pos = 0;
      else begin
         if ((pos - 1) % (S + 1) == S && int'(dut_d) != int'((pos - 1) / (S + 1) == 6)) begin
            if (m_err == 0) m_first = (pos - 1) / (S + 1);
            m_err++;
         end
         pos++;
         if (pos == N + 1) m_pass = int'(m_err == 0);
      end
   end

   always @(negedge clk) begin
      automatic int b = int'(pos >= 1 && pos <= N);
      chk("busy", busy, b);
      chk("done", done, int'(pos == N + 1));
      chk("abc", {dut_a, dut_b, dut_c}, b ? (pos - 1) / (S + 1) : 0);
      chk("pass", pass, m_pass);
      chk("err_count", err_count, m_err);
      chk("first_err_vec", first_err_vec, m_first);
   end

   task automatic pulse_start();
      @(negedge clk) start = 1;
      @(negedge clk) start = 0;
   endtask

   task automatic wait_vec(input int v);
      for (int i = 0; i < 100 && int'({dut_a, dut_b, dut_c}) != v; i++) @(negedge clk);
      chk("wait_vec", {dut_a, dut_b, dut_c}, v);
   endtask

   task automatic sweep(input int m, input bit poke, output int cyc);
      bit poked = 0;
      mode = m;
      pulse_start();
      cyc = 1;
      while (!done && cyc < 100) begin
         start = poke && !poked && {dut_a, dut_b, dut_c} == 3'd3;
         poked |= start;
         @(negedge clk);
         cyc++;
      end
      start = 0;
   endtask

   initial begin
      int cyc, dcount;
      @(negedge clk);
      chk("rst busy", busy, 0);
      chk("rst err", err_count, 0);
      #1 rst_n = 1;
      sweep(0, 0, cyc);
      chk("good latency", cyc, 25);
      chk("good pass", pass, 1);
      chk("good err", err_count, 0);
      sweep(1, 0, cyc);
      chk("stuck0 err", err_count, 1);
      chk("stuck0 first", first_err_vec, 6);
      chk("stuck0 pass", pass, 0);
      sweep(2, 0, cyc);
      chk("stuck1 err", err_count, 7);
      chk("stuck1 first", first_err_vec, 0);
      chk("stuck1 pass", pass, 0);
      sweep(0, 1, cyc);
      chk("restart latency", cyc, 25);
      chk("restart pass", pass, 1);
      mode = 4;
      pulse_start();
      wait_vec(3);
      repeat (S) @(negedge clk);
      abort = 1;
      @(negedge clk) abort = 0;
      chk("abort busy", busy, 0);
      chk("abort err", err_count, 0);
      chk("abort done", done, 0);
      mode = 0;
      pulse_start();
      wait_vec(5);
      #1 rst_n = 0;
      #1 chk("reset busy", busy, 0);
      chk("reset abc", {dut_a, dut_b, dut_c}, 0);
      chk("reset pass", pass, 0);
      @(negedge clk) #1 rst_n = 1;
      dcount = 0;
      repeat (40) @(negedge clk) dcount += int'(done);
      chk("reset no done", dcount, 0);
      sweep(0, 0, cyc);
      chk("post reset pass", pass, 1);
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         start = $urandom_range(0, 7) == 0;
         abort = $urandom_range(0, 39) == 0;
         rnd = 1'($urandom);
         if (!busy) mode = $urandom_range(0, 3);
         if ($urandom_range(0, 999) == 0) begin
            #1 rst_n = 0;
            #2 rst_n = 1;
         end
      end
      @(negedge clk);
      start = 0;
      abort = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
